// File: rtl/uart_transmitter.sv
// ---------------------------------------------------------------------------
// uart_transmitter
//
// Purpose:
//   Serialises one byte per request into an asynchronous frame on a line
//   that idles high. The frame is a start bit (0), then data bits LSB first,
//   then an optional even-parity bit, then a stop bit (1). Each bit is held
//   for CLKS_PER_BIT clock cycles.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit (1..65535)
//
// Optional build macro:
//   UART_TX_PARITY_EN  when defined, an even-parity bit is inserted
//                      between the last data bit and the stop bit.
//
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   synchronous reset, active-low
//   load  in   one-cycle transmit request, accepted only when idle
//   data  in   [7:0] byte to send, captured with an accepted load
//   tx    out  registered serial line
//   busy  out  registered, high while a frame is in flight
// ---------------------------------------------------------------------------
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy
);

    localparam logic [15:0] CNT_MAX = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t      state_reg, state_next;
    logic        tx_reg, tx_next;
    logic        busy_reg, busy_next;
    logic [15:0] cnt_reg, cnt_next;
    logic [2:0]  bit_idx_reg, bit_idx_next;
    logic [7:0]  shift_reg, shift_next;

    logic        bit_done;
    logic [2:0]  bit_idx_inc;

    assign bit_done    = (cnt_reg == CNT_MAX);
    assign bit_idx_inc = bit_idx_reg + 3'd1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= IDLE;
            tx_reg      <= 1'b1;
            busy_reg    <= 1'b0;
            cnt_reg     <= 16'd0;
            bit_idx_reg <= 3'd0;
            shift_reg   <= 8'd0;
        end else begin
            state_reg   <= state_next;
            tx_reg      <= tx_next;
            busy_reg    <= busy_next;
            cnt_reg     <= cnt_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
        end
    end

    // tx is registered, so the value for the next bit period is chosen on
    // the edge that ends the current one; this makes tx fall on the very
    // edge that accepts load.
    always_comb begin
        state_next   = state_reg;
        tx_next      = tx_reg;
        busy_next    = busy_reg;
        cnt_next     = cnt_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;

        case (state_reg)
            IDLE: begin
                tx_next      = 1'b1;
                busy_next    = 1'b0;
                cnt_next     = 16'd0;
                bit_idx_next = 3'd0;
                if (load) begin
                    shift_next = data;
                    state_next = START;
                    tx_next    = 1'b0;
                    busy_next  = 1'b1;
                end
            end

            START: begin
                if (bit_done) begin
                    cnt_next     = 16'd0;
                    bit_idx_next = 3'd0;
                    state_next   = DATA;
                    tx_next      = shift_reg[0];
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end

            DATA: begin
                if (bit_done) begin
                    cnt_next = 16'd0;
                    if (bit_idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
                        tx_next    = ^shift_reg;
`else
                        state_next = STOP;
                        tx_next    = 1'b1;
`endif
                    end else begin
                        bit_idx_next = bit_idx_inc;
                        tx_next      = shift_reg[bit_idx_inc];
                    end
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    cnt_next   = 16'd0;
                    state_next = STOP;
                    tx_next    = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
`endif

            STOP: begin
                if (bit_done) begin
                    cnt_next   = 16'd0;
                    state_next = IDLE;
                    tx_next    = 1'b1;
                    busy_next  = 1'b0;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end

            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
                busy_next  = 1'b0;
                cnt_next   = 16'd0;
            end
        endcase
    end

    assign tx   = tx_reg;
    assign busy = busy_reg;

endmodule

// File: tb/tb_uart_transmitter.sv
// ---------------------------------------------------------------------------
// tb_uart_transmitter
//
// Directed bench for uart_transmitter. Two instances share clk and rst:
// u_dut1 uses CLKS_PER_BIT=1, u_dut4 uses CLKS_PER_BIT=4. Expected line
// sequences are written out by hand. The 4-cycle test expects a parity bit
// when UART_TX_PARITY_EN is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_transmitter;

    logic       clk;
    logic       rst;
    logic       load1, load4;
    logic [7:0] data1, data4;
    logic       tx1, tx4;
    logic       busy1, busy4;

    int n_checks = 0;
    int n_fail   = 0;

    uart_transmitter #(.CLKS_PER_BIT(1)) u_dut1 (
        .clk  (clk),
        .rst  (rst),
        .load (load1),
        .data (data1),
        .tx   (tx1),
        .busy (busy1)
    );

    uart_transmitter #(.CLKS_PER_BIT(4)) u_dut4 (
        .clk  (clk),
        .rst  (rst),
        .load (load4),
        .data (data4),
        .tx   (tx4),
        .busy (busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Advance one rising edge and sample 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            step();
            check({tag, "_tx"}, 32'(tx1), 32'd1);
            check({tag, "_busy"}, 32'(busy1), 32'd0);
        end
    endtask

    // Sends byte b on the 1-cycle instance and checks the 10-cycle frame
    // against exp (exp[9] is the first bit on the line). If inject_at is
    // in 1..9, a load of 0x3C is pulsed before that edge while busy.
    task automatic frame1(input string tag, input logic [7:0] b,
                          input logic [9:0] exp, input int inject_at);
        @(negedge clk);
        load1 = 1'b1;
        data1 = b;
        step();
        check({tag, "_tx0"}, 32'(tx1), 32'(exp[9]));
        check({tag, "_busy0"}, 32'(busy1), 32'd1);
        for (int i = 1; i < 10; i++) begin
            @(negedge clk);
            if (i == inject_at) begin
                load1 = 1'b1;
                data1 = 8'h3C;
            end else begin
                load1 = 1'b0;
            end
            step();
            check($sformatf("%s_tx%0d", tag, i), 32'(tx1), 32'(exp[9-i]));
            check($sformatf("%s_busy%0d", tag, i), 32'(busy1), 32'd1);
        end
        @(negedge clk);
        load1 = 1'b0;
        step();
        check({tag, "_end_tx"}, 32'(tx1), 32'd1);
        check({tag, "_end_busy"}, 32'(busy1), 32'd0);
        $display("frame %s byte=%02h done", tag, b);
    endtask

    initial begin
        logic [10:0] exp4;
        int          nbits4;

        rst   = 1'b0;
        load1 = 1'b1;
        load4 = 1'b1;
        data1 = 8'hAA;
        data4 = 8'h55;

        // Reset wins over load: line stays idle on both instances.
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_tx1", 32'(tx1), 32'd1);
            check("rst_busy1", 32'(busy1), 32'd0);
            check("rst_tx4", 32'(tx4), 32'd1);
            check("rst_busy4", 32'(busy4), 32'd0);
        end
        @(negedge clk);
        load1 = 1'b0;
        load4 = 1'b0;
        rst   = 1'b1;
        check_idle("post_rst", 3);
        $display("reset sequence done");

        // 0xAA: start 0, bits 0,1,0,1,0,1,0,1, stop 1
        frame1("aa", 8'hAA, 10'b0_01010101_1, -1);

        check_idle("gap15", 15);

        // 0x5C: start 0, bits 0,0,1,1,1,0,1,0, stop 1
        frame1("5c", 8'h5C, 10'b0_00111010_1, -1);

        // Load pulse during bit period 4 is dropped; no second frame.
        frame1("aa_inj", 8'hAA, 10'b0_01010101_1, 4);
        check_idle("no_second", 12);

        // Reset during data bit 3 of 0xFF.
        @(negedge clk);
        load1 = 1'b1;
        data1 = 8'hFF;
        step();
        check("ff_start_tx", 32'(tx1), 32'd0);
        @(negedge clk);
        load1 = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            check($sformatf("ff_bit%0d_tx", i - 1), 32'(tx1), 32'd1);
            check($sformatf("ff_bit%0d_busy", i - 1), 32'(busy1), 32'd1);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        check("ff_abort_tx", 32'(tx1), 32'd1);
        check("ff_abort_busy", 32'(busy1), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        check_idle("ff_after", 12);
        $display("mid-frame reset done");

        // load held high: one idle cycle between frames, then restart.
        @(negedge clk);
        load1 = 1'b1;
        data1 = 8'h00;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("hold_tx%0d", i), 32'(tx1), (i == 9) ? 32'd1 : 32'd0);
            check($sformatf("hold_busy%0d", i), 32'(busy1), 32'd1);
        end
        step();
        check("hold_gap_tx", 32'(tx1), 32'd1);
        check("hold_gap_busy", 32'(busy1), 32'd0);
        step();
        check("hold_restart_tx", 32'(tx1), 32'd0);
        check("hold_restart_busy", 32'(busy1), 32'd1);
        @(negedge clk);
        load1 = 1'b0;
        for (int i = 0; i < 9; i++) step();
        check_idle("hold_after", 3);
        $display("held load done");

        // CLKS_PER_BIT=4, byte 0x01.
`ifdef UART_TX_PARITY_EN
        exp4   = 11'b0_10000000_1_1;
        nbits4 = 11;
`else
        exp4   = 11'b0_10000000_1_0;
        nbits4 = 10;
`endif
        @(negedge clk);
        load4 = 1'b1;
        data4 = 8'h01;
        for (int b = 0; b < nbits4; b++) begin
            for (int c = 0; c < 4; c++) begin
                step();
                if (b == 0 && c == 0) begin
                    @(negedge clk);
                    load4 = 1'b0;
                    #1;
                end
                check($sformatf("cpb4_b%0d_c%0d_tx", b, c), 32'(tx4), 32'(exp4[10-b]));
                check($sformatf("cpb4_b%0d_c%0d_busy", b, c), 32'(busy4), 32'd1);
            end
        end
        step();
        check("cpb4_end_tx", 32'(tx4), 32'd1);
        check("cpb4_end_busy", 32'(busy4), 32'd0);
        $display("frame cpb4 byte=01 bits=%0d done", nbits4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
